// File: rtl/binary_frame_gen_if.sv
// binary_frame_gen_if: pixel stream produced by the synthetic binary frame source.
// The master side is the generator; the slave side is a morphology stage or a bench.
interface binary_frame_gen_if;
    logic        vsync_o;
    logic        hsync_o;
    logic        data_en_o;
    logic [15:0] data_o;
    logic        frame_done_o;

    modport master (output vsync_o, hsync_o, data_en_o, data_o, frame_done_o);
    modport slave  (input  vsync_o, hsync_o, data_en_o, data_o, frame_done_o);
endinterface

// File: rtl/binary_frame_gen.sv
// binary_frame_gen: synthetic binary video source (blank / disc / checkerboard /
// noisy disc) replacing the camera + binarisation path for bring-up.
// Pipeline: counters -> stage 1 (offsets, segment decodes) -> stage 2 (squares,
// compare, registered outputs); counter-to-output latency is 2 clocks.
// Optional feature macro: BINARY_FRAME_GEN_NOISE_EN adds the LFSR and makes mode 3
// a noisy disc; without it mode 3 draws the plain disc.
module binary_frame_gen #(
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 4,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic [1:0]         mode_i,
    input  logic [10:0]        ball_x_i,
    input  logic [10:0]        ball_y_i,
    input  logic [7:0]         radius_i,
    binary_frame_gen_if.master vid,
    output logic               busy_o
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int STAGES  = 2;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [11:0]   X_ORG      = 12'(H_SYNC + H_BP);
    localparam logic [11:0]   Y_ORG      = 12'(V_SYNC + V_BP);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            running;
    logic            frame_start;
    logic            frame_end;
    logic            h_act, v_act, pix_act;

    // frame parameters, frozen for the whole frame
    logic [1:0]      mode_sh;
    logic [10:0]     cx_sh, cy_sh;
    logic [7:0]      rad_sh;

    logic [11:0]     x, y, dx, dy;
    logic [15:0]     r_sq;

    // stage 1 registers
    logic            s1_hs, s1_vs, s1_de, s1_chk, s1_noise;
    logic [1:0]      s1_mode;
    logic [11:0]     s1_adx, s1_ady;
    logic [15:0]     s1_rsq;

    // stage 2 combinational
    logic [21:0]     dx_sq, dy_sq;
    logic [22:0]     dist_sq;
    logic            disc_hit;
    logic            obj;

    // frame activity and frame-end tags travel alongside the data pipeline
    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] fe_pipe;

    function automatic logic [11:0] abs12(input logic [11:0] v);
        return v[11] ? (~v + 12'd1) : v;
    endfunction

    assign running     = (state != IDLE);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign frame_end   = running && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign h_act       = (h_cnt >= H_ACT_BEG) && (h_cnt <= H_ACT_LAST);
    assign v_act       = (v_cnt >= V_ACT_BEG) && (v_cnt <= V_ACT_LAST);
    assign pix_act     = running && h_act && v_act;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state: a frame, once begun, always runs to its last clock
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (run_i) state_nxt = RUN;
            RUN: begin
                // run_i dropping on the final clock already completes the frame
                if (!run_i) state_nxt = frame_end ? IDLE : STOP;
            end
            STOP: if (frame_end) state_nxt = run_i ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // raster counters; parked at the origin while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!running) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // shadow the frame parameters at the frame origin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_sh <= '0;
            cx_sh   <= '0;
            cy_sh   <= '0;
            rad_sh  <= '0;
        end else if (frame_start) begin
            mode_sh <= mode_i;
            cx_sh   <= ball_x_i;
            cy_sh   <= ball_y_i;
            rad_sh  <= radius_i;
        end
    end

    // active-area coordinates and centre offsets (12-bit two's complement)
    assign x    = 12'(h_cnt) - X_ORG;
    assign y    = 12'(v_cnt) - Y_ORG;
    assign dx   = x - {1'b0, cx_sh};
    assign dy   = y - {1'b0, cy_sh};
    assign r_sq = 16'(rad_sh) * 16'(rad_sh);

`ifdef BINARY_FRAME_GEN_NOISE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // noise LFSR: restarts every frame so each frame's noise pattern repeats
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              lfsr <= LFSR_SEED;
        else if (frame_start) lfsr <= LFSR_SEED;
        else if (pix_act)     lfsr <= {lfsr[14:0], lfsr_fb};
    end
`endif

    // stage 1: segment decodes, offset magnitudes, per-pixel pattern bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_de    <= 1'b0;
            s1_chk   <= 1'b0;
            s1_noise <= 1'b0;
            s1_mode  <= '0;
            s1_adx   <= '0;
            s1_ady   <= '0;
            s1_rsq   <= '0;
        end else begin
            s1_hs    <= running && (h_cnt < H_SYNC_END);
            s1_vs    <= running && (v_cnt < V_SYNC_END);
            s1_de    <= pix_act;
            s1_chk   <= x[3] ^ y[3];
`ifdef BINARY_FRAME_GEN_NOISE_EN
            s1_noise <= (lfsr[7:0] == 8'h00);
`else
            s1_noise <= 1'b0;
`endif
            s1_mode  <= mode_sh;
            s1_adx   <= abs12(dx);
            s1_ady   <= abs12(dy);
            s1_rsq   <= r_sq;
        end
    end

    // stage 2 arithmetic: the squares only need 22 bits inside the active area
    assign dx_sq    = 22'(s1_adx) * 22'(s1_adx);
    assign dy_sq    = 22'(s1_ady) * 22'(s1_ady);
    assign dist_sq  = 23'(dx_sq) + 23'(dy_sq);
    assign disc_hit = (dist_sq <= 23'(s1_rsq));

    // pattern select
    always_comb begin
        obj = 1'b0;
        case (s1_mode)
            2'd1: obj = disc_hit;
            2'd2: obj = s1_chk;
`ifdef BINARY_FRAME_GEN_NOISE_EN
            2'd3: obj = disc_hit ^ s1_noise;
`else
            2'd3: obj = disc_hit | (s1_noise & 1'b0);
`endif
            default: obj = 1'b0;
        endcase
    end

    // frame activity / frame-end shift registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            fe_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], running};
            fe_pipe  <= {fe_pipe[STAGES-2:0], frame_end};
        end
    end

    // stage 2: registered stream outputs; frame_done trails the last pixel clock by one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid.vsync_o      <= 1'b0;
            vid.hsync_o      <= 1'b0;
            vid.data_en_o    <= 1'b0;
            vid.data_o       <= '0;
            vid.frame_done_o <= 1'b0;
        end else begin
            vid.vsync_o      <= s1_vs;
            vid.hsync_o      <= s1_hs;
            vid.data_en_o    <= s1_de;
            vid.data_o       <= (s1_de && obj) ? 16'hFFFF : 16'h0000;
            vid.frame_done_o <= fe_pipe[STAGES-1];
        end
    end

    // busy covers the delayed stream of every frame and its done pulse
    assign busy_o = vld_pipe[STAGES-1] | vid.frame_done_o;

endmodule

// File: tb/tb_binary_frame_gen.sv
// tb_binary_frame_gen: directed bench for binary_frame_gen with a 16x12 active area
// (28 clocks/line, 18 lines/frame).
module tb_binary_frame_gen;
    localparam int HA = 16;
    localparam int VA = 12;
    localparam int NPIX = HA * VA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [10:0] ball_x_i = 11'd0;
    logic [10:0] ball_y_i = 11'd0;
    logic [7:0]  radius_i = 8'd0;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    binary_frame_gen_if vid();

    binary_frame_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_i    (run_i),
        .mode_i   (mode_i),
        .ball_x_i (ball_x_i),
        .ball_y_i (ball_y_i),
        .radius_i (radius_i),
        .vid      (vid),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    // per-frame statistics collected on the falling edge; a frame_done pulse closes one frame
    int acc_clk = 0, acc_hs = 0, acc_vs = 0, acc_lines = 0, acc_de = 0, acc_obj = 0, acc_bad = 0;
    int last_clk = 0, last_hs = 0, last_vs = 0, last_lines = 0, last_de = 0, last_obj = 0, last_bad = 0;
    int frames = 0;
    logic prev_hs = 1'b0;
    logic [15:0] acc_pix [NPIX];
    logic [15:0] last_pix [NPIX];
    logic [15:0] saved_pix [NPIX];

    always @(negedge clk) begin
        if (rst) begin
            acc_clk = 0; acc_hs = 0; acc_vs = 0; acc_lines = 0; acc_de = 0; acc_obj = 0; acc_bad = 0;
            prev_hs = 1'b0;
        end else begin
            if (vid.frame_done_o) begin
                last_clk = acc_clk; last_hs = acc_hs; last_vs = acc_vs; last_lines = acc_lines;
                last_de = acc_de; last_obj = acc_obj; last_bad = acc_bad; last_pix = acc_pix;
                frames++;
                acc_clk = 0; acc_hs = 0; acc_vs = 0; acc_lines = 0; acc_de = 0; acc_obj = 0; acc_bad = 0;
            end
            acc_clk++;
            if (vid.hsync_o) acc_hs++;
            if (vid.hsync_o && !prev_hs) acc_lines++;
            prev_hs = vid.hsync_o;
            if (vid.vsync_o) acc_vs++;
            if (vid.data_en_o) begin
                if (acc_de < NPIX) acc_pix[acc_de] = vid.data_o;
                if (vid.data_o == 16'hFFFF) acc_obj++;
                else if (vid.data_o != 16'h0000) acc_bad++;
                acc_de++;
            end else if (vid.data_o !== 16'h0000) begin
                acc_bad++;
            end
        end
    end

    function automatic logic [15:0] disc_px(input int px, input int py, input int cx, input int cy, input int r);
        return (((px - cx) * (px - cx) + (py - cy) * (py - cy)) <= r * r) ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic logic [15:0] chk_px(input int px, input int py);
        return (((px / 8) % 2) != ((py / 8) % 2)) ? 16'hFFFF : 16'h0000;
    endfunction

    // wait for n frame_done pulses (bounded), returning just after a falling edge
    task automatic wait_done(input int n);
        for (int k = 0; k < n; k++) begin
            int  f0;
            bit  seen;
            f0 = frames;
            seen = 1'b0;
            for (int i = 0; i < 1500 && !seen; i++) begin
                @(posedge clk);
                if (frames != f0) seen = 1'b1;
            end
            if (!seen) begin
                tests++; fails++;
                $display("FAIL wait_done: frame_done_o pulses got 0, required 1 within 1500 clocks");
            end
            @(negedge clk);
        end
    endtask

    // edge index (0 = the edge that leaves IDLE) at which hsync_o / data_en_o first show
    task automatic measure_start(output int hs_e, output int de_e);
        hs_e = -1;
        de_e = -1;
        for (int e = 0; e < 300; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (vid.hsync_o && hs_e < 0) hs_e = e;
            if (vid.data_en_o) begin
                de_e = e;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++; if (vid.hsync_o !== 1'b0) begin fails++; $display("FAIL rst_hsync: got %b, want 0", vid.hsync_o); end
        tests++; if (vid.vsync_o !== 1'b0) begin fails++; $display("FAIL rst_vsync: got %b, want 0", vid.vsync_o); end
        tests++; if (vid.data_en_o !== 1'b0) begin fails++; $display("FAIL rst_data_en: got %b, want 0", vid.data_en_o); end
        tests++; if (vid.data_o !== 16'h0000) begin fails++; $display("FAIL rst_data: got %h, want 0000", vid.data_o); end
        tests++; if (vid.frame_done_o !== 1'b0) begin fails++; $display("FAIL rst_done: got %b, want 0", vid.frame_done_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, want 0", busy_o); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        tests++; if ({busy_o, vid.hsync_o, vid.vsync_o} !== 3'b000) begin
            fails++; $display("FAIL idle_quiet: busy/hs/vs got %b, want 000", {busy_o, vid.hsync_o, vid.vsync_o});
        end
    endtask

    task automatic test_timing;
        int hs_e, de_e;
        mode_i = 2'd0;
        run_i  = 1'b1;
        measure_start(hs_e, de_e);
        tests++; if (hs_e != 2) begin fails++; $display("FAIL first_hsync_edge: got %0d, want 2", hs_e); end
        tests++; if (de_e != 122) begin fails++; $display("FAIL first_pixel_edge: got %0d, want 122", de_e); end
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL busy_running: got %b, want 1", busy_o); end
        wait_done(2);
        tests++; if (last_clk != 504) begin fails++; $display("FAIL frame_clocks: got %0d, want 504", last_clk); end
        tests++; if (last_lines != 18) begin fails++; $display("FAIL frame_lines: got %0d, want 18", last_lines); end
        tests++; if (last_hs != 72) begin fails++; $display("FAIL hsync_clocks: got %0d, want 72", last_hs); end
        tests++; if (last_vs != 56) begin fails++; $display("FAIL vsync_clocks: got %0d, want 56", last_vs); end
        tests++; if (last_de != 192) begin fails++; $display("FAIL de_clocks: got %0d, want 192", last_de); end
        tests++; if (last_obj != 0) begin fails++; $display("FAIL blank_objects: got %0d, want 0", last_obj); end
        tests++; if (last_bad != 0) begin fails++; $display("FAIL blank_bad_data: got %0d, want 0", last_bad); end
    endtask

    task automatic test_disc;
        int nbad, rmin, rmax, r6bad;
        logic [15:0] want;
        mode_i = 2'd1; ball_x_i = 11'd8; ball_y_i = 11'd6; radius_i = 8'd2;
        wait_done(2);
        nbad = 0; rmin = 99; rmax = -1; r6bad = 0;
        for (int py = 0; py < VA; py++) begin
            for (int px = 0; px < HA; px++) begin
                want = disc_px(px, py, 8, 6, 2);
                if (last_pix[py * HA + px] !== want) nbad++;
                if (last_pix[py * HA + px] === 16'hFFFF) begin
                    if (py < rmin) rmin = py;
                    if (py > rmax) rmax = py;
                end
                if (py == 6 && (last_pix[py * HA + px] === 16'hFFFF) != (px >= 6 && px <= 10)) r6bad++;
            end
        end
        tests++; if (last_obj != 13) begin fails++; $display("FAIL disc_objects: got %0d, want 13", last_obj); end
        tests++; if (rmin != 4 || rmax != 8) begin fails++; $display("FAIL disc_rows: got %0d..%0d, want 4..8", rmin, rmax); end
        tests++; if (r6bad != 0) begin fails++; $display("FAIL disc_row6: got %0d wrong pixels, want 0", r6bad); end
        tests++; if (nbad != 0) begin fails++; $display("FAIL disc_map: got %0d wrong pixels, want 0", nbad); end
    endtask

    task automatic test_checker;
        mode_i = 2'd2;
        wait_done(2);
        tests++; if (last_pix[0] !== 16'h0000) begin fails++; $display("FAIL chk_0_0: got %h, want 0000", last_pix[0]); end
        tests++; if (last_pix[8] !== 16'hFFFF) begin fails++; $display("FAIL chk_8_0: got %h, want ffff", last_pix[8]); end
        tests++; if (last_pix[8 * HA + 8] !== 16'h0000) begin fails++; $display("FAIL chk_8_8: got %h, want 0000", last_pix[8 * HA + 8]); end
        tests++; if (last_obj != 96) begin fails++; $display("FAIL chk_objects: got %0d, want 96", last_obj); end
    endtask

    task automatic test_midframe;
        int nbad_cur, nbad_nxt;
        wait_done(1);
        repeat (200) @(negedge clk);
        mode_i = 2'd1; ball_x_i = 11'd3;
        wait_done(1);
        nbad_cur = 0;
        for (int i = 0; i < NPIX; i++) if (last_pix[i] !== chk_px(i % HA, i / HA)) nbad_cur++;
        tests++; if (nbad_cur != 0 || last_obj != 96) begin
            fails++; $display("FAIL mid_current_frame: got %0d wrong pixels, %0d objects, want 0 and 96", nbad_cur, last_obj);
        end
        wait_done(1);
        nbad_nxt = 0;
        for (int i = 0; i < NPIX; i++) if (last_pix[i] !== disc_px(i % HA, i / HA, 3, 6, 2)) nbad_nxt++;
        tests++; if (nbad_nxt != 0 || last_obj != 13) begin
            fails++; $display("FAIL mid_next_frame: got %0d wrong pixels, %0d objects, want 0 and 13", nbad_nxt, last_obj);
        end
    endtask

    task automatic test_stop;
        bit found;
        int extra_hs, extra_done;
        wait_done(1);
        repeat (100) @(negedge clk);
        run_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge clk);
            if (vid.frame_done_o) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL stop_done: frame_done_o got none, want one pulse"); end
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL stop_busy_at_done: got %b, want 1", busy_o); end
        @(negedge clk);
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL stop_busy_after: got %b, want 0", busy_o); end
        tests++; if (last_de != 192) begin fails++; $display("FAIL stop_frame_complete: got %0d pixels, want 192", last_de); end
        extra_hs = 0; extra_done = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (vid.hsync_o) extra_hs++;
            if (vid.frame_done_o || busy_o) extra_done++;
        end
        tests++; if (extra_hs != 0 || extra_done != 0) begin
            fails++; $display("FAIL stop_quiet: got %0d hsync, %0d done/busy clocks, want 0 and 0", extra_hs, extra_done);
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        int hs_e, de_e, rst_done;
        mode_i = 2'd2;
        run_i  = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge clk);
            if (vid.data_en_o && vid.data_o == 16'hFFFF) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rmid_reach_active: got no object pixel, want one"); end
        #1 rst = 1'b1;
        #1;
        tests++; if ({vid.hsync_o, vid.vsync_o, vid.data_en_o, vid.frame_done_o, busy_o} !== 5'b0) begin
            fails++; $display("FAIL rmid_ctrl_low: got %b, want 00000",
                              {vid.hsync_o, vid.vsync_o, vid.data_en_o, vid.frame_done_o, busy_o});
        end
        tests++; if (vid.data_o !== 16'h0000) begin fails++; $display("FAIL rmid_data_low: got %h, want 0000", vid.data_o); end
        rst_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (vid.frame_done_o) rst_done++;
        end
        rst = 1'b0;
        if (vid.frame_done_o) rst_done++;
        measure_start(hs_e, de_e);
        tests++; if (rst_done != 0) begin fails++; $display("FAIL rmid_no_done: got %0d pulses, want 0", rst_done); end
        tests++; if (hs_e != 2) begin fails++; $display("FAIL rmid_restart_hsync: got %0d, want 2", hs_e); end
        tests++; if (de_e != 122) begin fails++; $display("FAIL rmid_restart_pixel: got %0d, want 122", de_e); end
        wait_done(1);
        tests++; if (last_de != 192 || last_obj != 96) begin
            fails++; $display("FAIL rmid_restart_frame: got %0d pixels %0d objects, want 192 and 96", last_de, last_obj);
        end
    endtask

    task automatic test_noise;
        int nsame, nref;
        mode_i = 2'd3; ball_x_i = 11'd8; ball_y_i = 11'd6; radius_i = 8'd2;
        wait_done(2);
        saved_pix = last_pix;
        wait_done(1);
        nsame = 0;
        nref  = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (last_pix[i] !== saved_pix[i]) nsame++;
            if (last_pix[i] !== disc_px(i % HA, i / HA, 8, 6, 2)) nref++;
        end
        tests++; if (nsame != 0) begin fails++; $display("FAIL mode3_repeat: got %0d differing pixels, want 0", nsame); end
`ifdef BINARY_FRAME_GEN_NOISE_EN
        tests++; if (last_de != 192) begin fails++; $display("FAIL mode3_pixels: got %0d, want 192", last_de); end
`else
        tests++; if (nref != 0) begin fails++; $display("FAIL mode3_is_disc: got %0d wrong pixels, want 0", nref); end
`endif
    endtask

    initial begin
        test_reset;
        test_timing;
        test_disc;
        test_checker;
        test_midframe;
        test_stop;
        test_reset_mid;
        test_noise;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time got 2ms, want completion earlier");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/binary_frame_gen.md
# binary_frame_gen

Synthetic binary video source for the find-ball pipeline. It drives the same vsync/hsync/data_en/16-bit pixel stream that the morphology stages consume, and it has no camera. Pixels are only 16'hFFFF (object) or 16'h0000 (background), drawn from a selectable pattern: blank, disc ("ball"), checkerboard, or noisy disc. It sits in place of the OV5640 capture and binarisation path for bring-up and for closed-loop verification of the erode/dilate/centroid chain.

## Interface
- H_SYNC, 4, hsync width in clocks
- H_BP, 4, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- H_FP, 4, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 2, vertical back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 2, vertical front porch
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- run_i  in  1  level; request frame generation
- mode_i  in  2  0 blank, 1 disc, 2 checkerboard (8x8 cells), 3 noisy disc
- ball_x_i  in  11  disc centre column (active-area coordinates)
- ball_y_i  in  11  disc centre row
- radius_i  in  8  disc radius
- vsync_o  out  1  active-high, V_SYNC lines long
- hsync_o  out  1  active-high, H_SYNC clocks long
- data_en_o  out  1  high on active pixels only
- data_o  out  16  16'hFFFF or 16'h0000; 0 whenever data_en_o is low
- frame_done_o  out  1  one-clock pulse after the last clock of each frame
- busy_o  out  1  high while a frame is in progress

## Operation
- State machine:
  - IDLE: counters held at 0 and all outputs low. Go to RUN on the first clock with run_i=1.
  - RUN: generate frames back-to-back. If run_i=0 at any point, go to STOP.
  - STOP: finish the current frame. At the frame end, go to IDLE if run_i=0, or return to RUN (next frame follows with no gap) if run_i=1.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 with H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
  - Segment order in both directions is sync, back porch, active, front porch.
  - hsync when h_cnt<H_SYNC. vsync when v_cnt<V_SYNC.
  - Active when both counters are inside their active windows.
  - Active coordinates: x=h_cnt-H_SYNC-H_BP, y=v_cnt-V_SYNC-V_BP.
- Frame parameters: mode_i, ball_x_i, ball_y_i and radius_i are sampled into shadow registers at h_cnt=0, v_cnt=0. Changes mid-frame have no effect until the next frame.
- Pixel rules:
  - Disc: pixel is object if dx²+dy²<=r², where dx=x-cx and dy=y-cy are 12-bit signed and the squares are 22-bit unsigned. Compare with a 23-bit sum against a 16-bit r². No wrap: the disc clips at the frame edges.
  - Checkerboard: pixel is object if x[3]^y[3].
  - Noisy disc: disc result XOR (lfsr[7:0]==0).
    - lfsr is a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
    - It advances once per active pixel and is reseeded at each frame start.
- Radius 0: the disc covers only the centre pixel.
- A centre outside the active area is legal: only clipped pixels, if any, are drawn.
- busy_o is high in RUN and STOP.
- frame_done_o fires at the wrap of v_cnt from V_TOTAL-1, aligned with the delayed stream.

## Timing
- Counter-to-output latency is fixed at 2 clocks:
  - stage 1 registers dx/dy and the segment decodes;
  - stage 2 registers the squares, compare and outputs.
- vsync_o, hsync_o, data_en_o and data_o are delayed identically and stay mutually aligned.
- The first hsync_o rises 2 clocks after the clock on which IDLE→RUN is taken.
- Reset values: all outputs 0, state IDLE, counters 0, LFSR = seed.
- Reset asserted mid-frame truncates the frame immediately. Outputs go low asynchronously and no frame_done_o is generated.
- IDLE to first active pixel: 2 + (V_SYNC+V_BP)·H_TOTAL + H_SYNC+H_BP clocks.

## Configuration
- BINARY_FRAME_GEN_NOISE_EN:
  - Defined: LFSR present and mode 3 is the noisy disc.
  - Undefined: no LFSR logic, and mode 3 is identical to mode 1.

## Test plan
All scenarios use small parameters: H_ACTIVE=16, V_ACTIVE=12, porches and syncs at defaults.
- Timing, run_i=1, mode 0:
  - period is 28 clocks/line and 18 lines/frame (504 clocks);
  - hsync_o high 4 clocks, vsync_o high 56 clocks;
  - 192 data_en_o clocks per frame, data_o all 0.
- Disc, mode 1, ball (8,6), r=2:
  - exactly 13 data_en_o pixels equal 16'hFFFF, rows 4..8;
  - row 6 covers x=6..10.
- Checkerboard, mode 2:
  - pixel (0,0)=0, (8,0)=FFFF, (8,8)=0;
  - 96 object pixels per frame.
- Mid-frame control:
  - change ball_x_i and mode_i mid-frame: the current frame is unchanged and the new values appear in the next frame;
  - drop run_i mid-frame: the frame completes, one frame_done_o pulse, busy_o falls 1 clock later, no further hsync_o.
- Reset and noise:
  - assert rst during the active area: all outputs 0 in the same cycle;
  - after release with run_i=1, the frame restarts from v_cnt=0;
  - with NOISE_EN defined, mode 3 gives identical pixel sequences in two consecutive frames.
